// File: rtl/seq_serializer_pkg.sv
// seq_serializer shared types and width helpers.
// SEQ_SERIALIZER_PARITY_EN enables the trailing even-parity bit.
package seq_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  function automatic int div_w(input int d);
    return $clog2(d > 1 ? d : 2);
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_DIV   = 1;
  localparam int DEF_WIDTH = 8;
  localparam int DIV_W     = $clog2(DEF_DIV > 1 ? DEF_DIV : 2);
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period prescaler: one-cycle tick at the end of every DIV cycles.
// restart realigns the count so a fresh frame's first bit is full length.
module bit_tick_gen
  import seq_serializer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int DW = div_w(DIV);

  generate
    if (DIV == 1) begin : g_nodiv
      logic unused_in;
      assign unused_in = ^{clk, rst, restart, en};
      assign tick = 1'b1;
    end else begin : g_div
      logic [DW-1:0] div_cnt;
      logic          wrap;

      assign wrap = (div_cnt == DW'(DIV - 1));
      assign tick = en && wrap;

      always_ff @(posedge clk) begin
        if (rst || restart) begin
          div_cnt <= '0;
        end else if (en) begin
          div_cnt <= wrap ? '0 : div_cnt + DW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/seq_serializer.sv
// Double-buffered MSB-first parallel-to-serial front end.
// Build option: SEQ_SERIALIZER_PARITY_EN appends an even-parity bit.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DIV      = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hb;
  logic             hb_full;
  logic [CW-1:0]    bit_cnt;
  logic             tick;
  logic             xfer;
  logic             last;
  logic             wend;
  logic             load_now;
  logic             idle_load;
  logic [WIDTH-1:0] lw;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             par;
`endif

  assign din_ready = !hb_full && !rst;
  assign busy      = (state != IDLE) || hb_full;
  assign xfer      = din_valid && din_ready;

`ifdef SEQ_SERIALIZER_PARITY_EN
  assign last = (state == PARITY);
`else
  assign last = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));
`endif

  assign wend      = tick && last;
  assign idle_load = (state == IDLE) && xfer;
  // HB drains first; a direct din load at word end only when HB is empty
  assign load_now  = idle_load || (wend && (hb_full || xfer));
  assign lw        = hb_full ? hb : din;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(idle_load),
    .en     (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      hb         <= '0;
      hb_full    <= 1'b0;
      bit_cnt    <= '0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      if (load_now) begin
        state      <= SHIFT;
        sr         <= {lw[WIDTH-2:0], 1'b0};
        sout       <= lw[WIDTH-1];
        sout_valid <= 1'b1;
        bit_cnt    <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par        <= ^lw;
`endif
      end else if (wend) begin
        state      <= IDLE;
        sout       <= IDLE_BIT;
        sout_valid <= 1'b0;
      end else if (tick && state == SHIFT) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
        if (bit_cnt == CW'(WIDTH - 1)) begin
          state <= PARITY;
          sout  <= par;
        end else begin
`else
        begin
`endif
          sout    <= sr[WIDTH-1];
          sr      <= {sr[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (wend && hb_full) begin
        hb_full <= 1'b0;
      end else if (xfer && state != IDLE && !wend) begin
        hb      <= din;
        hb_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: DIV=1 and DIV=3 instances
// checked each cycle against a frame-timeline model.
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 4 + PB;

  logic       clk;
  logic       rst;
  logic [3:0] din [2];
  logic       vld [2];
  logic       rdy [2];
  logic       sout [2];
  logic       sval [2];
  logic       busy [2];

  int   dv [2] = '{1, 3};
  logic ib [2] = '{1'b0, 1'b1};

  int         acc_t [2][64];
  int         st_t  [2][64];
  logic [3:0] wv    [2][64];
  int         nw [2];
  int         bu [2];

  logic [63:0] rec [2];
  int          nrec [2];
  int          run [2];
  int          maxrun [2];

  int cyc;
  int nvec;
  int nerr;

  seq_serializer #(.WIDTH(4), .DIV(1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(vld[0]),
    .din_ready(rdy[0]), .sout(sout[0]), .sout_valid(sval[0]),
    .busy(busy[0])
  );

  seq_serializer #(.WIDTH(4), .DIV(3), .IDLE_BIT(1'b1)) u_b (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(vld[1]),
    .din_ready(rdy[1]), .sout(sout[1]), .sout_valid(sval[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d,
                     input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got %b want %b",
               nm, d, cyc, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Frame timeline: word i occupies [st, st+FL*div); HB holds it in [acc, st).
  function automatic void mexp(input int d, input int t,
                               output logic so, output logic sv,
                               output logic bz, output logic rd);
    logic hbf;
    so  = ib[d];
    sv  = 1'b0;
    bz  = 1'b0;
    hbf = 1'b0;
    for (int i = 0; i < nw[d]; i++) begin
      int fe;
      int j;
      fe = st_t[d][i] + FL * dv[d];
      if (st_t[d][i] <= t && t < fe) begin
        j  = (t - st_t[d][i]) / dv[d];
        so = (j < 4) ? wv[d][i][3-j] : ^wv[d][i];
        sv = 1'b1;
      end
      if (acc_t[d][i] <= t && t < fe) bz = 1'b1;
      if (acc_t[d][i] <= t && t < st_t[d][i]) hbf = 1'b1;
    end
    rd = !rst && !hbf;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic eso, esv, ebz, erd;
      mexp(d, cyc, eso, esv, ebz, erd);
      if (cyc > 0) begin
        chk("sout", d, sout[d], eso);
        chk("sout_valid", d, sval[d], esv);
        chk("busy", d, busy[d], ebz);
        chk("din_ready", d, rdy[d], erd);
      end
      if (sval[d] === 1'b1) begin
        rec[d] = {rec[d][62:0], sout[d]};
        nrec[d]++;
        run[d]++;
        if (run[d] > maxrun[d]) maxrun[d] = run[d];
      end else begin
        run[d] = 0;
      end
      if (rst) begin
        nw[d] = 0;
        bu[d] = 0;
      end else if (vld[d] && erd && nw[d] < 64) begin
        int s;
        s = (cyc + 1 > bu[d]) ? cyc + 1 : bu[d];
        acc_t[d][nw[d]] = cyc + 1;
        st_t[d][nw[d]]  = s;
        wv[d][nw[d]]    = din[d];
        nw[d]++;
        bu[d] = s + FL * dv[d];
      end
    end
  end

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      rec[d]    = '0;
      nrec[d]   = 0;
      run[d]    = 0;
      maxrun[d] = 0;
    end
  endtask

  task automatic send(input int d, input logic [3:0] w);
    logic r;
    int   n;
    din[d] = w;
    vld[d] = 1'b1;
    r = 1'b0;
    n = 0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = rdy[d];
      @(posedge clk);
      #2;
      n++;
    end
    vld[d] = 1'b0;
    if (!r) begin
      nerr++;
      $display("FAIL send_timeout dut%0d word %b", d, w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    nw   = '{0, 0};
    bu   = '{0, 0};
    rst  = 1'b1;
    vld  = '{1'b0, 1'b0};
    din  = '{4'h0, 4'h0};
    clr();
    idle(3);
    rst = 1'b0;
    idle(2);

    clr();
    send(0, 4'b1011);
    idle(10);
    chkv("single_bits", rec[0], (PB != 0) ? 64'b10111 : 64'b1011);
    chkv("single_len", 64'(nrec[0]), 64'(FL));

    clr();
    send(0, 4'b1011);
    send(0, 4'b1011);
    send(0, 4'b1010);
    idle(20);
`ifdef SEQ_SERIALIZER_PARITY_EN
    chkv("b2b_bits", rec[0], 64'b101111011110100);
`else
    chkv("b2b_bits", rec[0], 64'b101110111010);
`endif
    chkv("b2b_gapless", 64'(maxrun[0]), 64'(3 * FL));

    clr();
    send(0, 4'b1100);
    idle(FL - 1);
    send(0, 4'b0110);
    idle(14);
`ifdef SEQ_SERIALIZER_PARITY_EN
    chkv("bypass_bits", rec[0], 64'b1100001100);
`else
    chkv("bypass_bits", rec[0], 64'b11000110);
`endif
    chkv("bypass_gapless", 64'(maxrun[0]), 64'(2 * FL));

    clr();
    send(1, 4'b1001);
    idle(24);
`ifdef SEQ_SERIALIZER_PARITY_EN
    chkv("div3_bits", rec[1], 64'b111000000111000);
`else
    chkv("div3_bits", rec[1], 64'b111000000111);
`endif
    chkv("div3_len", 64'(nrec[1]), 64'(3 * FL));

    clr();
    send(0, 4'b1001);
    idle(10);
    chkv("par_1001", rec[0], (PB != 0) ? 64'b10010 : 64'b1001);

    send(0, 4'b1011);
    send(0, 4'b0101);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", 0, rdy[0], 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sout", 0, sout[0], 1'b0);
    chk("rst_valid", 0, sval[0], 1'b0);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_ready_after", 0, rdy[0], 1'b1);
    @(posedge clk);
    #2;

    clr();
    send(0, 4'b0111);
    idle(10);
    chkv("post_rst_bits", rec[0], (PB != 0) ? 64'b01111 : 64'b0111);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
